// File: rtl/mem_arbiter.sv
// Purpose: two-master round-robin arbiter onto a single shared slave bus, with a per-transaction timeout.
// Latency: grant and s_valid one cycle after a request; mx_ready follows s_ready combinationally.
// Backpressure: the owner waits on s_ready; the non-owner is held off until IDLE; a stuck slave ends the transfer with err.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    // Counter value on the last BUSY cycle that is still allowed to wait.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic        last_m1;   // 1 when m1 won the most recent completed transfer
    logic [7:0]  busy_cnt;
    logic        busy0;
    logic        busy1;
    logic        own_vld;
    logic        timeout;
    logic        finish;

    // Decode owner, timeout and completion for the current cycle.
    always_comb begin
        busy0   = (state == BUSY0);
        busy1   = (state == BUSY1);
        own_vld = (busy0 && m0_valid) || (busy1 && m1_valid);
        // A slave response in the final cycle wins over the timeout.
        timeout = own_vld && !s_ready && (busy_cnt == CNT_LAST);
        finish  = own_vld && (s_ready || timeout);
    end

    // Arbitration FSM: state, grant, last-winner pointer and timeout counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            grant    <= 2'b00;
            last_m1  <= 1'b1;
            busy_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    busy_cnt <= 8'd0;
                    // On contention the master that did not win last goes first.
                    if (m0_valid && (!m1_valid || last_m1)) begin
                        state <= BUSY0;
                        grant <= 2'b01;
                    end else if (m1_valid) begin
                        state <= BUSY1;
                        grant <= 2'b10;
                    end
                end
                BUSY0, BUSY1: begin
                    if (!own_vld) begin
                        // Abandoned request: no completion, so fairness pointer stays put.
                        state    <= IDLE;
                        grant    <= 2'b00;
                        busy_cnt <= 8'd0;
                    end else if (finish) begin
                        state    <= IDLE;
                        grant    <= 2'b00;
                        busy_cnt <= 8'd0;
                        last_m1  <= busy1;
                    end else begin
                        busy_cnt <= busy_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    grant    <= 2'b00;
                    busy_cnt <= 8'd0;
                end
            endcase
        end
    end

    // Slave request mux from the owner and completion routing back to it only.
    always_comb begin
        s_valid  = own_vld;
        s_addr   = 32'd0;
        s_wdata  = 32'd0;
        s_wstrb  = 4'd0;
        if (busy0) begin
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
            s_wstrb = m0_wstrb;
        end else if (busy1) begin
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
            s_wstrb = m1_wstrb;
        end
        m0_ready = busy0 && finish;
        m1_ready = busy1 && finish;
        m0_err   = busy0 && timeout;
        m1_err   = busy1 && timeout;
        m0_rdata = (busy0 && own_vld && s_ready) ? s_rdata : 32'd0;
        m1_rdata = (busy1 && own_vld && s_ready) ? s_rdata : 32'd0;
    end

endmodule
